// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding, SPI mode constants
// and the helper that maps mode bits and sclk edges onto sample/shift strobes.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  localparam logic CPOL_IDLE_LOW     = 1'b0;
  localparam logic CPOL_IDLE_HIGH    = 1'b1;
  localparam logic CPHA_LEAD_SAMPLE  = 1'b0;
  localparam logic CPHA_TRAIL_SAMPLE = 1'b1;

  // Returns {sample, shift} for the given mode and detected sclk edges.
  function automatic logic [1:0] edge_roles(input logic cpol, input logic cpha,
                                            input logic rise, input logic fall);
    logic lead;
    logic trail;
    case (cpol)
      CPOL_IDLE_LOW: begin
        lead  = rise;
        trail = fall;
      end
      CPOL_IDLE_HIGH: begin
        lead  = fall;
        trail = rise;
      end
      default: begin
        lead  = 1'b0;
        trail = 1'b0;
      end
    endcase
    case (cpha)
      CPHA_LEAD_SAMPLE:  edge_roles = {lead, trail};
      CPHA_TRAIL_SAMPLE: edge_roles = {trail, lead};
      default:           edge_roles = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin; the reset value is the
// pin's idle level so no spurious edge is seen after reset.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      chain_r <= {STAGES{RST_VAL}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave supporting all four CPOL/CPHA modes, oversampling the SPI pins on
// clk_i, with a one-entry TX buffer and back-to-back words inside one frame.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_cs_n_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_vld_i,
  output logic                  tx_rdy_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_vld_o,
  output logic                  tx_underrun_o,
  output logic                  busy_o
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_d_r, cs_n_d_r;
  logic sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;
  logic sample_s, shift_s;
  logic entry_s, act_sample_s, act_shift_s;
  logic load_s, accept_s, word_done_s, active_nxt_s;

  spi_state_e state_r, state_nxt_s;
  logic                  cpol_r, cpha_r;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic                  load_pending_r;
  logic [DATA_WIDTH-1:0] buf_r;
  logic                  buf_empty_r;
  logic [DATA_WIDTH-1:0] tx_shift_r, tx_shift_nxt_s;
  logic [DATA_WIDTH-2:0] rx_shift_r;
  logic [DATA_WIDTH-1:0] rx_word_s;
  logic [DATA_WIDTH-1:0] rx_data_r;
  logic                  rx_vld_r, underrun_r, miso_r, oe_r, busy_r;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d(spi_sclk_i), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d(spi_cs_n_i), .q(cs_n_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d(spi_mosi_i), .q(mosi_s)
  );

  // Delayed copies of the synced pins for edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_d_r <= 1'b0;
      cs_n_d_r <= 1'b1;
    end else begin
      sclk_d_r <= sclk_s;
      cs_n_d_r <= cs_n_s;
    end
  end

  assign sclk_rise_s = sclk_s & ~sclk_d_r;
  assign sclk_fall_s = ~sclk_s & sclk_d_r;
  assign cs_fall_s   = ~cs_n_s & cs_n_d_r;
  assign cs_rise_s   = cs_n_s & ~cs_n_d_r;

  assign {sample_s, shift_s} = edge_roles(cpol_r, cpha_r, sclk_rise_s, sclk_fall_s);

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) state_nxt_s = ST_ACTIVE;
        else           state_nxt_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (cs_rise_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_ACTIVE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM decoded controls; a cs_n rise masks any coincident sclk edge.
  always_comb begin
    entry_s      = 1'b0;
    act_sample_s = 1'b0;
    act_shift_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        entry_s = cs_fall_s;
      end
      ST_ACTIVE: begin
        if (cs_rise_s) begin
          act_sample_s = 1'b0;
          act_shift_s  = 1'b0;
        end else begin
          act_sample_s = sample_s;
          act_shift_s  = shift_s;
        end
      end
      default: begin
        entry_s      = 1'b0;
        act_sample_s = 1'b0;
        act_shift_s  = 1'b0;
      end
    endcase
  end

  assign load_s       = (entry_s & (cpha_i == CPHA_LEAD_SAMPLE)) | (act_shift_s & load_pending_r);
  assign accept_s     = tx_vld_i & buf_empty_r;
  assign word_done_s  = act_sample_s & (bit_cnt_r == LAST_BIT);
  assign rx_word_s    = {rx_shift_r, mosi_s};
  assign active_nxt_s = (state_nxt_s == ST_ACTIVE);

  // Next TX shift value: load from the buffer (zeros on underrun) or shift left.
  always_comb begin
    tx_shift_nxt_s = tx_shift_r;
    if (load_s) begin
      if (buf_empty_r) tx_shift_nxt_s = '0;
      else             tx_shift_nxt_s = buf_r;
    end else if (act_shift_s) begin
      tx_shift_nxt_s = {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
    end else begin
      tx_shift_nxt_s = tx_shift_r;
    end
  end

  // One-entry TX buffer; a same-cycle load sees the empty buffer and the new word stays.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_r       <= '0;
      buf_empty_r <= 1'b1;
    end else if (accept_s) begin
      buf_r       <= tx_data_i;
      buf_empty_r <= 1'b0;
    end else if (load_s) begin
      buf_empty_r <= 1'b1;
    end
  end

  // TX shift register, MISO and underrun pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_shift_r <= '0;
      miso_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      tx_shift_r <= tx_shift_nxt_s;
      miso_r     <= active_nxt_s ? tx_shift_nxt_s[DATA_WIDTH-1] : 1'b0;
      underrun_r <= load_s & buf_empty_r;
    end
  end

  // Mode latch, bit counter, load request and RX shift register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cpol_r         <= 1'b0;
      cpha_r         <= 1'b0;
      bit_cnt_r      <= '0;
      load_pending_r <= 1'b0;
      rx_shift_r     <= '0;
    end else if (entry_s) begin
      cpol_r         <= cpol_i;
      cpha_r         <= cpha_i;
      bit_cnt_r      <= '0;
      load_pending_r <= (cpha_i != CPHA_LEAD_SAMPLE);
    end else if (word_done_s) begin
      bit_cnt_r      <= '0;
      load_pending_r <= 1'b1;
      rx_shift_r     <= rx_word_s[DATA_WIDTH-2:0];
    end else if (act_sample_s) begin
      bit_cnt_r      <= bit_cnt_r + CNT_W'(1);
      rx_shift_r     <= rx_word_s[DATA_WIDTH-2:0];
    end else if (act_shift_s) begin
      load_pending_r <= 1'b0;
    end
  end

  // Received word and status outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_data_r <= '0;
      rx_vld_r  <= 1'b0;
      oe_r      <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      rx_vld_r <= word_done_s;
      oe_r     <= active_nxt_s;
      busy_r   <= active_nxt_s;
      if (word_done_s) rx_data_r <= rx_word_s;
    end
  end

  assign spi_miso_o    = miso_r;
  assign spi_miso_oe_o = oe_r;
  assign tx_rdy_o      = buf_empty_r;
  assign rx_data_o     = rx_data_r;
  assign rx_vld_o      = rx_vld_r;
  assign tx_underrun_o = underrun_r;
  assign busy_o        = busy_r;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural SPI master drives frames and
// the expected MISO/RX words and underrun counts come from the exchange rules.
module tb_spi_slave;

  localparam int HP = 8;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       spi_sclk_i, spi_cs_n_i, spi_mosi_i;
  logic       spi_miso_o, spi_miso_oe_o;
  logic       cpol_i, cpha_i;
  logic [7:0] tx_data_i;
  logic       tx_vld_i, tx_rdy_o;
  logic [7:0] rx_data_o;
  logic       rx_vld_o, tx_underrun_o, busy_o;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mosi_w [3];
  logic [7:0] tx_w   [3];
  bit         sup_w  [3];
  logic [7:0] miso_w [3];
  logic [7:0] rx_q   [$];
  int         urun_cnt = 0;
  int         frame_id = 0;

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .spi_sclk_i(spi_sclk_i), .spi_cs_n_i(spi_cs_n_i), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o),
    .cpol_i(cpol_i), .cpha_i(cpha_i),
    .tx_data_i(tx_data_i), .tx_vld_i(tx_vld_i), .tx_rdy_o(tx_rdy_o),
    .rx_data_o(rx_data_o), .rx_vld_o(rx_vld_o),
    .tx_underrun_o(tx_underrun_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every rx_vld_o pulse and tx_underrun_o pulse.
  always @(negedge clk_i) begin
    if (rx_vld_o) rx_q.push_back(rx_data_o);
    if (tx_underrun_o) urun_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic push(input logic [7:0] d);
    int t = 0;
    while (!tx_rdy_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    check($sformatf("f%0d_tx_rdy_wait", frame_id), 32'(tx_rdy_o), 32'd1);
    tx_data_i = d;
    tx_vld_i  = 1'b1;
    @(negedge clk_i);
    tx_vld_i  = 1'b0;
  endtask

  // Behavioural master: clocks nbits, capturing MISO on each sample edge.
  task automatic run_frame(input logic cpol, input logic cpha, input int nbits, input bit raise);
    cpol_i = cpol;
    cpha_i = cpha;
    spi_sclk_i = cpol;
    spi_mosi_i = 1'b0;
    for (int k = 0; k < 3; k++) miso_w[k] = 8'h00;
    if (sup_w[0]) push(tx_w[0]);
    wait_cycles(HP);
    for (int i = 0; i < nbits; i++) begin
      int w = i / 8;
      int b = 7 - (i % 8);
      bit last = (i == nbits - 1);
      if (!cpha) begin
        if (i == 0) begin
          spi_mosi_i = mosi_w[0][7];
          spi_cs_n_i = 1'b0;
        end
        wait_cycles(HP);
        miso_w[w][b] = spi_miso_o;
        spi_sclk_i = ~cpol;
        wait_cycles(HP);
        spi_sclk_i = cpol;
        if (last) begin
          if (raise) spi_cs_n_i = 1'b1;
        end else begin
          spi_mosi_i = mosi_w[(i + 1) / 8][7 - ((i + 1) % 8)];
        end
      end else begin
        if (i == 0) begin
          spi_cs_n_i = 1'b0;
          wait_cycles(HP);
        end
        spi_sclk_i = ~cpol;
        spi_mosi_i = mosi_w[w][b];
        wait_cycles(HP);
        miso_w[w][b] = spi_miso_o;
        spi_sclk_i = cpol;
        wait_cycles(HP);
        if (last && raise) spi_cs_n_i = 1'b1;
      end
      if ((i % 8) == 1 && (w + 1) * 8 < nbits && sup_w[w + 1]) push(tx_w[w + 1]);
    end
    wait_cycles(HP);
  endtask

  task automatic check_frame(input int nbits, input int rb, input int ub);
    int nfull = nbits / 8;
    int nloads = (nbits + 7) / 8;
    int exp_ur = 0;
    logic [7:0] e;
    wait_cycles(2 * HP);
    for (int k = 0; k < nloads; k++) if (!sup_w[k]) exp_ur++;
    check($sformatf("f%0d_rx_count", frame_id), 32'(rx_q.size() - rb), 32'(nfull));
    for (int k = 0; k < nfull; k++) begin
      e = sup_w[k] ? tx_w[k] : 8'h00;
      check($sformatf("f%0d_miso_w%0d", frame_id, k), 32'(miso_w[k]), 32'(e));
      if (rx_q.size() > rb + k)
        check($sformatf("f%0d_rx_w%0d", frame_id, k), 32'(rx_q[rb + k]), 32'(mosi_w[k]));
    end
    check($sformatf("f%0d_underrun", frame_id), 32'(urun_cnt - ub), 32'(exp_ur));
    check($sformatf("f%0d_busy_idle", frame_id), 32'(busy_o), 32'd0);
    check($sformatf("f%0d_oe_idle", frame_id), 32'(spi_miso_oe_o), 32'd0);
    check($sformatf("f%0d_miso_idle", frame_id), 32'(spi_miso_o), 32'd0);
  endtask

  task automatic do_frame(input logic cpol, input logic cpha, input int nbits);
    int rb = rx_q.size();
    int ub = urun_cnt;
    frame_id++;
    run_frame(cpol, cpha, nbits, 1'b1);
    check_frame(nbits, rb, ub);
  endtask

  initial begin
    int rb, ub;
    rst_n_i = 1'b0;
    spi_sclk_i = 1'b0; spi_cs_n_i = 1'b1; spi_mosi_i = 1'b0;
    cpol_i = 1'b0; cpha_i = 1'b0; tx_data_i = 8'h00; tx_vld_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mosi_w[k] = 8'h00; tx_w[k] = 8'h00; sup_w[k] = 1'b0;
    end
    wait_cycles(3);
    rst_n_i = 1'b1;
    wait_cycles(2);
    check("reset_miso", 32'(spi_miso_o), 32'd0);
    check("reset_oe", 32'(spi_miso_oe_o), 32'd0);
    check("reset_rx_data", 32'(rx_data_o), 32'd0);
    check("reset_rx_vld", 32'(rx_vld_o), 32'd0);
    check("reset_underrun", 32'(tx_underrun_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_tx_rdy", 32'(tx_rdy_o), 32'd1);

    // Single-word exchange in all four modes.
    for (int m = 0; m < 4; m++) begin
      tx_w[0] = 8'hA5; mosi_w[0] = 8'h3C; sup_w[0] = 1'b1;
      do_frame(m[1], m[0], 8);
      check($sformatf("mode%0d_rx_data", m), 32'(rx_data_o), 32'h3C);
    end

    // Back-to-back words within one frame.
    tx_w[0] = 8'h11; tx_w[1] = 8'h22; mosi_w[0] = 8'h81; mosi_w[1] = 8'h42;
    sup_w[0] = 1'b1; sup_w[1] = 1'b1;
    do_frame(1'b0, 1'b0, 16);

    // Underrun: nothing buffered at frame start.
    sup_w[0] = 1'b0; sup_w[1] = 1'b0; mosi_w[0] = 8'h5E;
    do_frame(1'b0, 1'b0, 8);

    // Abort after 5 bits, then a full frame.
    sup_w[0] = 1'b1; tx_w[0] = 8'hA5; mosi_w[0] = 8'hFF;
    do_frame(1'b0, 1'b0, 5);
    tx_w[0] = 8'hC7; mosi_w[0] = 8'h1D;
    do_frame(1'b0, 1'b0, 8);

    // Reset after 3 bits, then a full frame.
    frame_id++;
    sup_w[0] = 1'b1; tx_w[0] = 8'h5A; mosi_w[0] = 8'hC3;
    rb = rx_q.size(); ub = urun_cnt;
    run_frame(1'b1, 1'b1, 3, 1'b0);
    check("midframe_busy", 32'(busy_o), 32'd1);
    check("midframe_oe", 32'(spi_miso_oe_o), 32'd1);
    rst_n_i = 1'b0;
    #1;
    check("rst_miso", 32'(spi_miso_o), 32'd0);
    check("rst_oe", 32'(spi_miso_oe_o), 32'd0);
    check("rst_rx_data", 32'(rx_data_o), 32'd0);
    check("rst_rx_vld", 32'(rx_vld_o), 32'd0);
    check("rst_underrun", 32'(tx_underrun_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_tx_rdy", 32'(tx_rdy_o), 32'd1);
    spi_cs_n_i = 1'b1; spi_sclk_i = 1'b0; spi_mosi_i = 1'b0;
    wait_cycles(4);
    rst_n_i = 1'b1;
    wait_cycles(HP);
    check("rst_no_rx_pulse", 32'(rx_q.size() - rb), 32'd0);
    check("rst_no_underrun", 32'(urun_cnt - ub), 32'd0);
    tx_w[0] = 8'h96; mosi_w[0] = 8'h69; sup_w[0] = 1'b1;
    do_frame(1'b0, 1'b1, 8);

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      logic cp, ch;
      int n;
      cp = 1'($urandom_range(0, 1));
      ch = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      for (int k = 0; k < 3; k++) begin
        mosi_w[k] = 8'($urandom);
        tx_w[k]   = 8'($urandom);
        sup_w[k]  = ($urandom_range(0, 3) != 0);
      end
      do_frame(cp, ch, n * 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per SPI word (>=2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per SPI input (>=2).
REQ-003 SHALL have port clk_i, input, 1, system clock; the block uses one clock only.
REQ-004 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports spi_sclk_i, spi_cs_n_i and spi_mosi_i, each input, 1, asynchronous SPI pins from the master.
REQ-006 SHALL have port spi_miso_o, output, 1, serial data to the master.
REQ-007 SHALL have port spi_miso_oe_o, output, 1, MISO driver enable.
REQ-008 SHALL have ports cpol_i and cpha_i, each input, 1, SPI mode; sampled only at frame start.
REQ-009 SHALL have port tx_data_i, input, DATA_WIDTH, next word to transmit.
REQ-010 SHALL have port tx_vld_i, input, 1, and port tx_rdy_o, output, 1, forming a valid/ready pair for tx_data_i.
REQ-011 SHALL have port rx_data_o, output, DATA_WIDTH, last received word.
REQ-012 SHALL have port rx_vld_o, output, 1, one-cycle pulse marking rx_data_o as new.
REQ-013 SHALL have port tx_underrun_o, output, 1, one-cycle pulse when a word loads with the TX buffer empty.
REQ-014 SHALL have port busy_o, output, 1, high while in ACTIVE.

Function
REQ-015 SHALL pass sclk, cs_n and mosi through SYNC_STAGES flops, then detect edges against one further registered copy.
REQ-016 SHALL define the leading edge as the sclk rise when CPOL=0 and the fall when CPOL=1; the trailing edge is the opposite.
REQ-017 SHALL use the leading edge as the sample edge and the trailing edge as the shift edge when CPHA=0; when CPHA=1 these roles are swapped.
REQ-018 SHALL implement a one-entry TX buffer: tx_rdy_o = buffer empty; a word is accepted on tx_vld_i && tx_rdy_o.
REQ-019 SHALL use the states IDLE and ACTIVE; IDLE goes to ACTIVE on a synced cs_n fall, and ACTIVE goes to IDLE on a synced cs_n rise.
REQ-020 SHALL, on entering ACTIVE: latch cpol_i and cpha_i, clear bit_cnt, and set load_pending.
REQ-021 SHALL, when CPHA=0, load the TX shift register in the same cycle as the cs_n fall is detected and clear load_pending.
REQ-022 SHALL, on a shift edge, load the TX shift register if load_pending is set (clearing it), otherwise shift left by one.
REQ-023 SHALL drive spi_miso_o from the registered MSB of the TX shift register, MSB first.
REQ-024 SHALL, on a load, take the buffer word and empty the buffer; if the buffer is empty it SHALL load all zeros and pulse tx_underrun_o.
REQ-025 SHALL treat an accept and a load in the same cycle as follows: the load sees the pre-accept buffer, and the accepted word is kept for the next load.
REQ-026 SHALL, on a sample edge, shift synced mosi into the RX shift register MSB-first and increment bit_cnt.
REQ-027 SHALL, on the DATA_WIDTH-th sample, wrap bit_cnt to 0 and set load_pending; one cycle later rx_data_o holds the word and rx_vld_o pulses.
REQ-028 SHALL support back-to-back words while cs_n stays low, with no bit gap.
REQ-029 SHALL, on a cs_n rise mid-word, discard the partial RX word (no rx_vld_o), not pulse tx_underrun_o, and leave the buffer untouched.
REQ-030 SHALL ignore sclk edges in IDLE.
REQ-031 SHALL drive spi_miso_oe_o = 1 only in ACTIVE and hold spi_miso_o = 0 in IDLE.
REQ-032 SHALL restrict operation to sclk high and low phases of at least SYNC_STAGES+2 clk_i cycles each; behaviour is undefined otherwise.
REQ-033 SHALL have a latency of SYNC_STAGES+1 clk_i cycles from an external sclk edge to its internal detection.

Reset
REQ-034 SHALL, on rst_n_i low, asynchronously reset: state IDLE, all synchronizers to idle levels (cs_n=1, sclk=0, mosi=0), spi_miso_o=0, spi_miso_oe_o=0, rx_data_o=0, rx_vld_o=0, tx_underrun_o=0, busy_o=0, buffer empty (tx_rdy_o=1), bit_cnt=0, load_pending=0.
REQ-035 SHALL, on reset asserted mid-frame, drop the frame with no pulses; after release the block waits for a fresh cs_n fall.

Structure
REQ-036 SHALL place the state encoding (IDLE, ACTIVE) and the CPOL/CPHA mode constants in a shared package spi_pkg.
REQ-037 SHALL implement synchronization in a sub-module spi_sync (parameterized depth and reset value), instantiated three times.

Verification
REQ-038 SHALL cover mode 0, DATA_WIDTH=8: buffer 0xA5, master sends 0x3C -> master receives 0xA5; rx_data_o=0x3C with one rx_vld_o pulse.
REQ-039 SHALL cover modes 1, 2 and 3: the same exchange, 0xA5 and 0x3C, gives the same results in each mode.
REQ-040 SHALL cover back-to-back words: buffer 0x11 then 0x22 within one cs_n frame, master sends 0x81, 0x42 -> MISO shows 0x11, 0x22; two rx_vld_o pulses with 0x81 and 0x42.
REQ-041 SHALL cover underrun: empty buffer at cs_n fall -> MISO shows 0x00 and tx_underrun_o pulses once.
REQ-042 SHALL cover abort: cs_n rises after 5 bits -> no rx_vld_o; busy_o=0; the next full frame receives correctly.
REQ-043 SHALL cover reset mid-frame: rst_n_i low after 3 bits -> all outputs at reset values; the next frame succeeds.
